// File: rtl/ddr3_ps_pkg.sv
// Shared definitions for the DDR3 read-capture clock phase-shift sequencer.
// Optional build macro: DDR3_PS_WRAP_EN (modulo phase tracking, see ddr3_ps_ctrl).
package ddr3_ps_pkg;

  localparam int DEF_POS_W     = 12;
  localparam int DEF_CNT_W     = 10;
  // 56 fine steps per VCO period x CLKOUT2_DIVIDE of 3
  localparam int DEF_PS_PERIOD = 168;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_ISSUE,
    PS_WAIT_DONE,
    PS_GAP
  } ps_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_ps_ctrl_if.sv
// Command channel between read-leveling/calibration logic and the phase-shift
// sequencer. The requester is the master; the sequencer is the slave.
interface ddr3_ps_ctrl_if
  import ddr3_ps_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_home;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_done;

  modport master (
    output cmd_valid,
    output cmd_home,
    output cmd_dir,
    output cmd_count,
    input  cmd_ready,
    input  cmd_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_home,
    input  cmd_dir,
    input  cmd_count,
    output cmd_ready,
    output cmd_done
  );

endinterface

// File: rtl/ddr3_ps_timeout.sv
// Loadable down-counter shared by the inter-step gap and the PSDONE watchdog.
// Loading N makes expire assert on the Nth cycle after the load cycle; a load
// of 0 never expires.
module ddr3_ps_timeout #(
  parameter int TMR_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] cnt;

  // Reload has priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign expire = (cnt == TMR_W'(1));

endmodule

// File: rtl/ddr3_ps_ctrl.sv
// MMCM fine phase-shift sequencer for the DDR3 read-capture clock.
// Runs in the clk_app domain (PSCLK = clk_app). Issues one PSEN pulse per step,
// waits for PSDONE (with watchdog), and tracks the resulting phase position.
// Optional build macro DDR3_PS_WRAP_EN: position wraps modulo PS_PERIOD,
// home takes the shorter direction and err_limit is tied low. Without it the
// position is signed and saturates at +/-PS_LIMIT.
module ddr3_ps_ctrl
  import ddr3_ps_pkg::*;
#(
  parameter int POS_W      = DEF_POS_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int PS_LIMIT   = 1024,
  parameter int PS_PERIOD  = DEF_PS_PERIOD,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk_app,
  input  logic                    rstdiv0,
  input  logic                    mmcm_locked,
  ddr3_ps_ctrl_if.slave           cmd_if,
  output logic                    PSEN,
  output logic                    PSINCDEC,
  input  logic                    PSDONE,
  output logic signed [POS_W-1:0] phase_pos,
  output logic                    busy,
  output logic                    err_limit,
  output logic                    err_timeout
);

  localparam int REM_W = imax(CNT_W, POS_W);
  localparam int TMR_W = $clog2(imax(imax(TIMEOUT, GAP_CYCLES), 1) + 1);
  // Watchdog load: PSDONE is accepted up to and including the cycle
  // TIMEOUT-1 after PSEN, so the error flag rises TIMEOUT cycles after PSEN.
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'((TIMEOUT > 1) ? (TIMEOUT - 1) : 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);
`ifdef DDR3_PS_WRAP_EN
  localparam logic signed [POS_W-1:0] POS_TOP = POS_W'(PS_PERIOD - 1);
`endif

  ps_state_t                state;
  logic [REM_W-1:0]         remaining;
  logic signed [POS_W-1:0]  pos;
  logic                     psen_q;
  logic                     incdec_q;
  logic                     ready_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_lim_q;
  logic                     err_to_q;

  logic                     accept;
  logic                     start_inc;
  logic [REM_W-1:0]         start_rem;
  int                       pos_i;
  logic signed [POS_W-1:0]  pos_after;
  logic                     blk_start;
  logic                     blk_after;
  logic                     blk_gap;
  logic                     tmr_load;
  logic [TMR_W-1:0]         tmr_val;
  logic                     tmr_expire;

  // Position one step away, honouring wrap-around when enabled.
  function automatic logic signed [POS_W-1:0] step_pos(
    input logic signed [POS_W-1:0] p,
    input logic                    inc
  );
`ifdef DDR3_PS_WRAP_EN
    if (inc) return (p == POS_TOP) ? '0 : p + POS_ONE;
    else     return (p == '0) ? POS_TOP : p - POS_ONE;
`else
    return inc ? p + POS_ONE : p - POS_ONE;
`endif
  endfunction

`ifndef DDR3_PS_WRAP_EN
  // Saturation guard: true when one more step would leave [-PS_LIMIT, PS_LIMIT].
  function automatic logic step_blocked(
    input logic signed [POS_W-1:0] p,
    input logic                    inc
  );
    int n;
    n = int'(p) + (inc ? 1 : -1);
    return (n > PS_LIMIT) || (n < -PS_LIMIT);
  endfunction
`endif

  assign cmd_if.cmd_ready = ready_q & mmcm_locked;
  assign cmd_if.cmd_done  = done_q;
  assign accept           = cmd_if.cmd_valid & cmd_if.cmd_ready;
  assign PSEN             = psen_q;
  assign PSINCDEC         = incdec_q;
  assign phase_pos        = pos;
  assign busy             = busy_q;
  assign err_timeout      = err_to_q;
`ifdef DDR3_PS_WRAP_EN
  assign err_limit        = 1'b0;
`else
  assign err_limit        = err_lim_q;
`endif

  // Decode a new command into direction and step count (home resolves from position).
  always_comb begin
    pos_i     = int'(pos);
    start_inc = cmd_if.cmd_dir;
    start_rem = REM_W'(cmd_if.cmd_count);
    if (cmd_if.cmd_home) begin
`ifdef DDR3_PS_WRAP_EN
      if (pos_i > PS_PERIOD / 2) begin
        start_inc = 1'b1;
        start_rem = REM_W'(PS_PERIOD - pos_i);
      end else begin
        start_inc = 1'b0;
        start_rem = REM_W'(pos_i);
      end
`else
      start_inc = pos[POS_W-1];
      start_rem = REM_W'((pos_i < 0) ? -pos_i : pos_i);
`endif
    end
  end

  // Limit checks for each point where a new step may be launched.
  always_comb begin
    pos_after = step_pos(pos, incdec_q);
`ifdef DDR3_PS_WRAP_EN
    blk_start = 1'b0;
    blk_after = 1'b0;
    blk_gap   = 1'b0;
`else
    blk_start = step_blocked(pos, start_inc);
    blk_after = step_blocked(pos_after, incdec_q);
    blk_gap   = step_blocked(pos, incdec_q);
`endif
  end

  // Arm the watchdog while PSEN is out, then the gap timer once PSDONE returns.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TO_LOAD;
    if (state == PS_ISSUE) begin
      tmr_load = 1'b1;
    end else if ((state == PS_WAIT_DONE) && PSDONE) begin
      tmr_load = 1'b1;
      tmr_val  = GAP_LOAD;
    end
  end

  ddr3_ps_timeout #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk      (clk_app),
    .rst      (rstdiv0),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Step sequencer: IDLE -> ISSUE -> WAIT_DONE -> (GAP ->) ISSUE ... -> IDLE.
  always_ff @(posedge clk_app) begin
    if (rstdiv0) begin
      state     <= PS_IDLE;
      remaining <= '0;
      pos       <= '0;
      psen_q    <= 1'b0;
      incdec_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_lim_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else if (!mmcm_locked) begin
      // MMCM relock resets its phase; drop the command silently.
      state     <= PS_IDLE;
      remaining <= '0;
      pos       <= '0;
      psen_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      psen_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        PS_IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept) begin
            incdec_q <= start_inc;
            if (start_rem == '0) begin
              done_q <= 1'b1;
            end else if (blk_start) begin
              err_lim_q <= 1'b1;
              remaining <= '0;
              done_q    <= 1'b1;
            end else begin
              remaining <= start_rem;
              state     <= PS_ISSUE;
              psen_q    <= 1'b1;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
        end

        PS_ISSUE: begin
          state <= PS_WAIT_DONE;
        end

        PS_WAIT_DONE: begin
          if (PSDONE) begin
            pos       <= pos_after;
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state   <= PS_IDLE;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (GAP_CYCLES != 0) begin
              state <= PS_GAP;
            end else if (blk_after) begin
              err_lim_q <= 1'b1;
              remaining <= '0;
              state     <= PS_IDLE;
              done_q    <= 1'b1;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              state  <= PS_ISSUE;
              psen_q <= 1'b1;
            end
          end else if (tmr_expire) begin
            err_to_q  <= 1'b1;
            remaining <= '0;
            state     <= PS_IDLE;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end

        PS_GAP: begin
          if (tmr_expire) begin
            if (blk_gap) begin
              err_lim_q <= 1'b1;
              remaining <= '0;
              state     <= PS_IDLE;
              done_q    <= 1'b1;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              state  <= PS_ISSUE;
              psen_q <= 1'b1;
            end
          end
        end

        default: begin
          state <= PS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_ps_ctrl.sv
// Randomized self-checking bench for ddr3_ps_ctrl with a step-level reference
// model and a behavioural MMCM that answers PSEN with PSDONE after a chosen
// latency (0 = never answers).
`timescale 1ns/1ps
module tb_ddr3_ps_ctrl;

  localparam int TB_POS_W   = 12;
  localparam int TB_CNT_W   = 10;
  localparam int TB_LIMIT   = 4;
  localparam int TB_PERIOD  = 168;
  localparam int TB_GAP     = 2;
  localparam int TB_TIMEOUT = 8;

  logic                       clk_app;
  logic                       rstdiv0;
  logic                       mmcm_locked;
  logic                       PSEN;
  logic                       PSINCDEC;
  logic                       PSDONE;
  logic signed [TB_POS_W-1:0] phase_pos;
  logic                       busy;
  logic                       err_limit;
  logic                       err_timeout;

  ddr3_ps_ctrl_if #(.CNT_W(TB_CNT_W)) cmd_if ();

  ddr3_ps_ctrl #(
    .POS_W      (TB_POS_W),
    .CNT_W      (TB_CNT_W),
    .PS_LIMIT   (TB_LIMIT),
    .PS_PERIOD  (TB_PERIOD),
    .GAP_CYCLES (TB_GAP),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk_app     (clk_app),
    .rstdiv0     (rstdiv0),
    .mmcm_locked (mmcm_locked),
    .cmd_if      (cmd_if),
    .PSEN        (PSEN),
    .PSINCDEC    (PSINCDEC),
    .PSDONE      (PSDONE),
    .phase_pos   (phase_pos),
    .busy        (busy),
    .err_limit   (err_limit),
    .err_timeout (err_timeout)
  );

  initial clk_app = 1'b0;
  always #5 clk_app = ~clk_app;

  int n_vec = 0;
  int n_err = 0;
  int mdl_pos = 0;
  bit mdl_lim = 0;
  bit mdl_to  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mdl_step(input int p, input bit inc);
`ifdef DDR3_PS_WRAP_EN
    return inc ? (p + 1) % TB_PERIOD : (p + TB_PERIOD - 1) % TB_PERIOD;
`else
    return inc ? p + 1 : p - 1;
`endif
  endfunction

  task automatic do_reset();
    rstdiv0          = 1'b1;
    mmcm_locked      = 1'b1;
    PSDONE           = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_home  = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_count = '0;
    repeat (3) @(negedge clk_app);
    chk("rst_psen", PSEN, 0);
    chk("rst_psincdec", PSINCDEC, 0);
    chk("rst_pos", $signed(phase_pos), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", cmd_if.cmd_done, 0);
    chk("rst_ready", cmd_if.cmd_ready, 0);
    chk("rst_err_limit", err_limit, 0);
    chk("rst_err_timeout", err_timeout, 0);
    rstdiv0 = 1'b0;
    @(negedge clk_app);
    chk("ready_after_rst", cmd_if.cmd_ready, 1);
    mdl_pos = 0;
    mdl_lim = 0;
    mdl_to  = 0;
  endtask

  // Wait (bounded) for cmd_ready and present a command for one cycle; returns
  // at the negedge of the cycle after acceptance.
  task automatic send_cmd(input bit home, input bit dir, input int count);
    int w;
    w = 0;
    while (!cmd_if.cmd_ready && w < 100) begin
      @(negedge clk_app);
      w++;
    end
    chk("cmd_ready", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_home  = home;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_count = count[TB_CNT_W-1:0];
    @(negedge clk_app);
    cmd_if.cmd_valid = 1'b0;
  endtask

  // lat_mode >= 0 uses that PSDONE latency for every step; -1 randomizes.
  task automatic do_cmd(input bit home, input bit dir, input int count, input int lat_mode);
    int m_pos, steps, n_iss, lat, budget, cyc;
    int n_psen, n_done, psen_cyc, done_pend, last_done, to_cyc, done_cyc, exp_done;
    bit m_dir, m_lim, m_to, to_pre;
    int lat_a[$];

    m_pos = mdl_pos;
    if (home) begin
`ifdef DDR3_PS_WRAP_EN
      if (m_pos > TB_PERIOD / 2) begin
        m_dir = 1'b1;
        steps = TB_PERIOD - m_pos;
      end else begin
        m_dir = 1'b0;
        steps = m_pos;
      end
`else
      m_dir = (m_pos < 0);
      steps = (m_pos < 0) ? -m_pos : m_pos;
`endif
    end else begin
      m_dir = dir;
      steps = count;
    end
    m_lim = 0;
    m_to  = 0;
    n_iss = 0;
    while (n_iss < steps && !m_lim && !m_to) begin
`ifndef DDR3_PS_WRAP_EN
      if ((m_pos + (m_dir ? 1 : -1) > TB_LIMIT) || (m_pos + (m_dir ? 1 : -1) < -TB_LIMIT))
        m_lim = 1;
`endif
      if (!m_lim) begin
        if (lat_mode >= 0) lat = lat_mode;
        else lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, TB_TIMEOUT - 1);
        lat_a.push_back(lat);
        n_iss++;
        if (lat == 0) m_to = 1;
        else m_pos = mdl_step(m_pos, m_dir);
      end
    end

    to_pre = err_timeout;
    send_cmd(home, dir, count);
    cyc       = 1;
    n_psen    = 0;
    n_done    = 0;
    psen_cyc  = -100;
    done_pend = -1;
    last_done = -100;
    to_cyc    = -1;
    done_cyc  = -1;
    budget    = (n_iss + 1) * (TB_TIMEOUT + TB_GAP + 4) + 10;
    while (cyc <= budget && n_done == 0) begin
      if (PSEN) begin
        n_psen++;
        chk("psincdec", PSINCDEC, m_dir);
        if (n_psen == 1) chk("psen_first", cyc, 1);
        else chk("psen_spacing", cyc - last_done, TB_GAP + 1);
        lat = (n_psen <= lat_a.size()) ? lat_a[n_psen-1] : 1;
        done_pend = (lat > 0) ? cyc + lat : -1;
        psen_cyc  = cyc;
      end
      PSDONE = (cyc == done_pend);
      if (PSDONE) last_done = cyc;
      if (err_timeout && !to_pre && to_cyc < 0) to_cyc = cyc;
      if (cmd_if.cmd_done) begin
        n_done++;
        done_cyc = cyc;
      end
      @(negedge clk_app);
      cyc++;
    end
    // Stray PSDONE while idle must be ignored.
    PSDONE = 1'b1;
    chk("no_extra_done", cmd_if.cmd_done, 0);
    chk("no_extra_psen", PSEN, 0);
    @(negedge clk_app);
    PSDONE = 1'b0;

    if (m_to)                   exp_done = psen_cyc + TB_TIMEOUT;
    else if (n_iss == 0)        exp_done = 1;
    else if (m_lim)             exp_done = last_done + TB_GAP + 1;
    else                        exp_done = last_done + 1;
    chk("n_done", n_done, 1);
    chk("n_psen", n_psen, n_iss);
    chk("done_cycle", done_cyc, exp_done);
    if (m_to && !to_pre) chk("timeout_cycle", to_cyc - psen_cyc, TB_TIMEOUT);
    mdl_pos = m_pos;
    mdl_lim = mdl_lim | m_lim;
    mdl_to  = mdl_to | m_to;
    chk("phase_pos", $signed(phase_pos), mdl_pos);
    chk("err_limit", err_limit, mdl_lim);
    chk("err_timeout", err_timeout, mdl_to);
    chk("busy_idle", busy, 0);
  endtask

  task automatic lock_drop_test();
    int cyc, n, p3, pend, n_done;
    bit dropped;
    do_reset();
    send_cmd(1'b0, 1'b1, 5);
    cyc = 1; n = 0; p3 = -1; pend = -1; n_done = 0; dropped = 0;
    while (!dropped && cyc < 200) begin
      if (PSEN) begin
        n++;
        pend = cyc + 3;
        if (n == 3) p3 = cyc;
      end
      PSDONE = (cyc == pend);
      if (cmd_if.cmd_done) n_done++;
      if (n == 3 && cyc == p3 + 1) begin
        chk("pos_before_drop", $signed(phase_pos), 2);
        chk("busy_before_drop", busy, 1);
        mmcm_locked = 1'b0;
        dropped = 1;
      end
      @(negedge clk_app);
      cyc++;
    end
    PSDONE = 1'b0;
    chk("drop_reached", dropped, 1);
    chk("drop_busy", busy, 0);
    chk("drop_pos", $signed(phase_pos), 0);
    chk("drop_psen", PSEN, 0);
    chk("drop_ready", cmd_if.cmd_ready, 0);
    if (cmd_if.cmd_done) n_done++;
    repeat (3) begin
      @(negedge clk_app);
      chk("ready_unlocked", cmd_if.cmd_ready, 0);
      if (cmd_if.cmd_done) n_done++;
    end
    mmcm_locked = 1'b1;
    @(negedge clk_app);
    chk("ready_relocked", cmd_if.cmd_ready, 1);
    chk("drop_no_done", n_done, 0);
    mdl_pos = 0;
  endtask

  initial begin
    do_reset();
`ifdef DDR3_PS_WRAP_EN
    do_cmd(1'b0, 1'b0, 1, 3);    // 0 -> 167
    do_cmd(1'b0, 1'b1, 1, 3);    // 167 -> 0
    do_cmd(1'b0, 1'b0, 18, 2);   // 0 -> 150
    do_cmd(1'b1, 1'b0, 0, 2);    // home: 18 inc steps -> 0
    do_cmd(1'b1, 1'b0, 0, 2);    // home at 0: immediate done
`else
    do_cmd(1'b0, 1'b1, 3, 5);    // 0 -> 3
    do_cmd(1'b0, 1'b0, 2, 5);    // 3 -> 1
    do_cmd(1'b1, 1'b1, 7, 5);    // home: one dec step -> 0
    do_cmd(1'b1, 1'b0, 0, 5);    // home at 0: immediate done
    do_cmd(1'b0, 1'b1, 10, 2);   // saturates at +4
    do_cmd(1'b0, 1'b1, 0, 2);    // zero count at the limit: no error path
    do_reset();
    do_cmd(1'b0, 1'b0, 1, 0);    // PSDONE never returns
    do_reset();
    do_cmd(1'b0, 1'b0, 1, TB_TIMEOUT - 1);  // PSDONE on the last accepted cycle
`endif
    lock_drop_test();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      do_cmd(($urandom_range(0, 4) == 0), $urandom_range(0, 1), $urandom_range(0, 6), -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
